// File: rtl/mips8_pkg.sv
// ============================================================================
// Module : mips8_pkg
// Brief  : Shared types and constants for the 8-bit multicycle MIPS control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips8_pkg;

    localparam int STATE_BITS = 4;

    // FETCH1..FETCH4 occupy 0..3 so the low state bits select the IR byte lane.
    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOP_NONE decodes to AND (all-zero) so idle states drive alucontrol=000.
    typedef logic [1:0] aluop_t;
    localparam aluop_t ALUOP_NONE  = 2'b00;
    localparam aluop_t ALUOP_ADD   = 2'b01;
    localparam aluop_t ALUOP_SUB   = 2'b10;
    localparam aluop_t ALUOP_FUNCT = 2'b11;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        aluop_t     aluop;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic [3:0] irwrite;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips8_multicycle_ctrl_if.sv
// ============================================================================
// Module : mips8_multicycle_ctrl_if
// Brief  : Control <-> datapath bundle; master is the control FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips8_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               memread;
    logic               memwrite;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [2:0]         alucontrol;
    logic               iord;
    logic               memtoreg;
    logic               regdst;
    logic               regwrite;
    logic [3:0]         irwrite;
    logic [1:0]         pcsrc;
    logic               pcen;
    logic               branch;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct, zero,
        output memread, memwrite, alusrca, alusrcb, alucontrol, iord,
               memtoreg, regdst, regwrite, irwrite, pcsrc, pcen, branch, state
    );

    modport slave (
        output op, funct, zero,
        input  memread, memwrite, alusrca, alusrcb, alucontrol, iord,
               memtoreg, regdst, regwrite, irwrite, pcsrc, pcen, branch, state
    );
endinterface

`default_nettype wire

// File: rtl/mips8_multicycle_ctrl_alu_decoder.sv
// ============================================================================
// Module : mips8_alu_decoder
// Brief  : Maps the FSM aluop and R-type funct field to an ALU select.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips8_alu_decoder
    import mips8_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_AND;
        unique case (aluop_i)
            ALUOP_NONE: alucontrol_o = ALU_AND;
            ALUOP_ADD:  alucontrol_o = ALU_ADD;
            ALUOP_SUB:  alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_AND;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips8_multicycle_ctrl.sv
// ============================================================================
// Module : mips8_multicycle_ctrl
// Brief  : Moore control FSM sequencing the 8-bit multicycle MIPS datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips8_multicycle_ctrl
    import mips8_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  wire logic                clk,
    input  wire logic                reset,
    mips8_multicycle_ctrl_if.master  bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    function automatic ctrl_t decode_state(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                c.aluop   = ALUOP_ADD;
                c.pcwrite = 1'b1;
                c.irwrite = 4'b0001 << s[1:0];
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = ALUOP_ADD;
            end
            S_LBRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_LBWR: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_SBWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWR: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.branch  = 1'b1;
                c.pcsrc   = 2'b01;
            end
            S_JEX: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = 2'b10;
            end
            S_ADDIWR: c.regwrite = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH1;
        case (state_q)
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_FETCH4;
            S_FETCH4: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH1;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    state_d = S_LBWR;
            S_RTYPEEX: state_d = S_RTYPEWR;
            S_ADDIEX:  state_d = S_ADDIWR;
            default:   state_d = S_FETCH1;
        endcase
    end

    // Outputs are registered from the next-state decode, so they always
    // equal decode_state(state_q) without a combinational decode stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH1;
            ctrl_q  <= decode_state(S_FETCH1);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_state(state_d);
        end
    end

    mips8_alu_decoder u_alu_decoder (
        .aluop_i      (ctrl_q.aluop),
        .funct_i      (bus.funct),
        .alucontrol_o (bus.alucontrol)
    );

    assign bus.memread  = ctrl_q.memread;
    assign bus.memwrite = ctrl_q.memwrite;
    assign bus.alusrca  = ctrl_q.alusrca;
    assign bus.alusrcb  = ctrl_q.alusrcb;
    assign bus.iord     = ctrl_q.iord;
    assign bus.memtoreg = ctrl_q.memtoreg;
    assign bus.regdst   = ctrl_q.regdst;
    assign bus.regwrite = ctrl_q.regwrite;
    assign bus.irwrite  = ctrl_q.irwrite;
    assign bus.pcsrc    = ctrl_q.pcsrc;
    assign bus.branch   = ctrl_q.branch;
    assign bus.pcen     = ctrl_q.pcwrite | (ctrl_q.branch & bus.zero);
    assign bus.state    = STATE_W'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_mips8_multicycle_ctrl.sv
// ============================================================================
// Module : tb_mips8_multicycle_ctrl
// Brief  : Instruction-level reference model checks of the control FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips8_multicycle_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips8_multicycle_ctrl_if #(.STATE_W(4)) bus ();

    mips8_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected control word per cycle of an instruction.
    typedef struct {
        logic       memread, memwrite, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alu;
        logic       iord, memtoreg, regdst, regwrite;
        logic [3:0] irwrite;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       pcen_is_zero;
        logic       branch;
    } step_t;

    step_t steps[$];

    function automatic step_t blank();
        step_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic build(input logic [5:0] op, input logic [5:0] funct);
        step_t s;
        steps.delete();
        for (int k = 0; k < 4; k++) begin
            s = blank();
            s.memread = 1'b1; s.alusrcb = 2'b01; s.alu = 3'b010;
            s.irwrite = 4'(1 << k); s.pcen = 1'b1;
            steps.push_back(s);
        end
        s = blank(); s.alusrcb = 2'b11; s.alu = 3'b010;
        steps.push_back(s);
        if (op == 6'b100000 || op == 6'b101000) begin
            s = blank(); s.alusrca = 1'b1; s.alusrcb = 2'b10; s.alu = 3'b010;
            steps.push_back(s);
            if (op == 6'b100000) begin
                s = blank(); s.memread = 1'b1; s.iord = 1'b1;
                steps.push_back(s);
                s = blank(); s.regwrite = 1'b1; s.memtoreg = 1'b1;
                steps.push_back(s);
            end else begin
                s = blank(); s.memwrite = 1'b1; s.iord = 1'b1;
                steps.push_back(s);
            end
        end else if (op == 6'b000000) begin
            s = blank(); s.alusrca = 1'b1; s.alu = funct_alu(funct);
            steps.push_back(s);
            s = blank(); s.regwrite = 1'b1; s.regdst = 1'b1;
            steps.push_back(s);
        end else if (op == 6'b000100) begin
            s = blank(); s.alusrca = 1'b1; s.alu = 3'b110; s.branch = 1'b1;
            s.pcsrc = 2'b01; s.pcen_is_zero = 1'b1;
            steps.push_back(s);
        end else if (op == 6'b000010) begin
            s = blank(); s.pcsrc = 2'b10; s.pcen = 1'b1;
            steps.push_back(s);
        end else if (op == 6'b001000) begin
            s = blank(); s.alusrca = 1'b1; s.alusrcb = 2'b10; s.alu = 3'b010;
            steps.push_back(s);
            s = blank(); s.regwrite = 1'b1;
            steps.push_back(s);
        end
    endtask

    function automatic logic [19:0] pack_exp(input step_t s, input logic z);
        return {s.memread, s.memwrite, s.alusrca, s.alusrcb, s.alu, s.iord,
                s.memtoreg, s.regdst, s.regwrite, s.irwrite, s.pcsrc,
                (s.pcen_is_zero ? z : s.pcen), s.branch};
    endfunction

    function automatic logic [19:0] pack_obs();
        return {bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb,
                bus.alucontrol, bus.iord, bus.memtoreg, bus.regdst,
                bus.regwrite, bus.irwrite, bus.pcsrc, bus.pcen, bus.branch};
    endfunction

    // zmode: 0/1 force zero, 2 random each cycle. abort_at: step index after
    // which reset is pulsed (-1 none, -2 pick at random occasionally).
    task automatic run_instr(input string tag, input logic [5:0] op,
                             input logic [5:0] funct, input int zmode,
                             input int abort_at);
        logic [19:0] obs;
        logic [19:0] exp;
        int          ab;
        bus.op    = op;
        bus.funct = funct;
        build(op, funct);
        ab = abort_at;
        if (ab == -2)
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, steps.size() - 1)) : -1;
        for (int i = 0; i < steps.size(); i++) begin
            bus.zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            obs = pack_obs();
            exp = pack_exp(steps[i], bus.zero);
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s step %0d: observed %05h expected %05h", tag, i, obs, exp);
            end
            checks++;
            assert (!(bus.memread && bus.memwrite) && $onehot0(bus.irwrite)) else begin
                errors++;
                $error("FAIL %s step %0d exclusivity: memread %b memwrite %b irwrite %b required exclusive/onehot0",
                       tag, i, bus.memread, bus.memwrite, bus.irwrite);
            end
            if (i == ab) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                checks++;
                assert (bus.regwrite === 1'b0 && bus.memwrite === 1'b0 && bus.irwrite === 4'b0001) else begin
                    errors++;
                    $error("FAIL %s reset-abort: observed regwrite %b memwrite %b irwrite %b required 0 0 0001",
                           tag, bus.regwrite, bus.memwrite, bus.irwrite);
                end
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] rop;
        logic [5:0] rfn;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("radd",   6'b000000, 6'b100000, 2, -1);
        run_instr("rslt",   6'b000000, 6'b101010, 2, -1);
        run_instr("rsub",   6'b000000, 6'b100010, 2, -1);
        run_instr("ror",    6'b000000, 6'b100101, 2, -1);
        run_instr("rbad",   6'b000000, 6'b111000, 2, -1);
        run_instr("lb",     6'b100000, 6'b000000, 2, -1);
        run_instr("sb",     6'b101000, 6'b000000, 2, -1);
        run_instr("beq_z1", 6'b000100, 6'b000000, 1, -1);
        run_instr("beq_z0", 6'b000100, 6'b000000, 0, -1);
        run_instr("j",      6'b000010, 6'b000000, 2, -1);
        run_instr("addi",   6'b001000, 6'b000000, 2, -1);
        run_instr("lb_abort", 6'b100000, 6'b000000, 2, 6);
        run_instr("illegal", 6'b111111, 6'b000000, 2, -1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: rop = 6'b100000;
                1: rop = 6'b101000;
                2: rop = 6'b000000;
                3: rop = 6'b000100;
                4: rop = 6'b000010;
                5: rop = 6'b001000;
                default: rop = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rfn = 6'b100000;
                1: rfn = 6'b100010;
                2: rfn = 6'b100100;
                3: rfn = 6'b100101;
                4: rfn = 6'b101010;
                default: rfn = 6'($urandom);
            endcase
            run_instr("rand", rop, rfn, 2, -2);
        end

        // Final return to FETCH1 after the last instruction.
        run_instr("tail", 6'b111111, 6'b000000, 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
